// File: rtl/ahb_lite_slave_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ahb_lite_slave_mem_pkg
// Description : Shared AHB-Lite type definitions, plus the slave state
//               encoding, memory depth and byte-lane mask helper.
// Revision    : 1.0 - initial release
// ============================================================================
package ahb_lite_slave_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } HTRANS_TYPE;

    typedef enum logic [2:0] {
        BYTE     = 3'd0,
        HALFWORD = 3'd1,
        WORD     = 3'd2,
        WORD2    = 3'd3,
        WORD4    = 3'd4,
        WORD8    = 3'd5,
        WORD16   = 3'd6,
        WORD32   = 3'd7
    } HSIZE_TYPE;

    typedef enum logic {
        OKAY  = 1'b0,
        ERROR = 1'b1
    } HRESP_TYPE;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } HWRITE_TYPE;

    typedef enum logic [2:0] {
        SINGLE = 3'd0,
        INCR   = 3'd1,
        WRAP4  = 3'd2,
        INCR4  = 3'd3,
        WRAP8  = 3'd4,
        INCR8  = 3'd5,
        WRAP16 = 3'd6,
        INCR16 = 3'd7
    } HBURST_TYPE;

    // Slave data-phase state
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } slave_state_t;

    localparam int c_SLAVE_ADDRWIDTH = 10;
    localparam int c_MEM_DEPTH       = 2 ** c_SLAVE_ADDRWIDTH;

    // Number of words for a given word-index width
    function automatic int mem_depth(input int aw);
        return 2 ** aw;
    endfunction

    // Little-endian byte-lane enables for a legal access; zero for oversize
    function automatic logic [3:0] byte_mask(input logic [2:0] size, input logic [1:0] addr);
        logic [3:0] m;
        m = 4'b0000;
        case (size)
            BYTE:     m = 4'b0001 << addr;
            HALFWORD: m = addr[1] ? 4'b1100 : 4'b0011;
            WORD:     m = 4'b1111;
            default:  m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_slave_ram.sv
`default_nettype none
// ============================================================================
// Module      : ahb_slave_ram
// Description : DEPTH x 32 word memory with per-byte write enables and a
//               registered read port. A write and a read to the same word at
//               the same edge return the freshly written lanes.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_slave_ram
    import ahb_lite_slave_mem_pkg::*;
#(
    parameter int ADDR_W = c_SLAVE_ADDRWIDTH,
    parameter int DEPTH  = c_MEM_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [31:0]       i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [31:0]       o_rdata
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;
    logic [31:0] w_rd_fwd;
    logic        w_same_word;

    assign w_same_word = (i_waddr == i_raddr);

    // Lanes being written this edge bypass the array into the read register
    generate
        for (genvar g = 0; g < 4; g++) begin : g_fwd
            assign w_rd_fwd[8*g +: 8] = (i_we[g] && w_same_word) ? i_wdata[8*g +: 8]
                                                                 : r_mem[i_raddr][8*g +: 8];
        end
    endgenerate

    // Byte-lane masked write; contents survive reset
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (i_we[b]) begin
                r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    // Read register: cleared by reset, loaded only on a read request
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= w_rd_fwd;
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/ahb_lite_slave_mem.sv
`default_nettype none
// ============================================================================
// Module      : ahb_lite_slave_mem
// Description : AHB-Lite memory slave with byte/halfword/word access,
//               programmable wait states and two-cycle ERROR responses.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_lite_slave_mem
    import ahb_lite_slave_mem_pkg::*;
#(
    parameter int ADDRWIDTH       = 32,
    parameter int DATAWIDTH       = 32,
    parameter int SLAVE_ADDRWIDTH = c_SLAVE_ADDRWIDTH,
    parameter int WAIT_STATES     = 0
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic                 HSEL,
    input  logic [ADDRWIDTH-1:0] HADDR,
    input  logic [1:0]           HTRANS,
    input  logic                 HWRITE,
    input  logic [2:0]           HSIZE,
    input  logic [2:0]           HBURST,
    input  logic [DATAWIDTH-1:0] HWDATA,
    input  logic                 HREADY,
    output logic                 HREADYOUT,
    output logic                 HRESP,
    output logic [DATAWIDTH-1:0] HRDATA
);

    localparam int         c_MEM_DEPTH_L = mem_depth(SLAVE_ADDRWIDTH);
    localparam logic [3:0] c_WAIT        = 4'(WAIT_STATES);

    slave_state_t               r_state, w_state_nxt;
    logic [3:0]                 r_cnt, w_cnt_nxt;
    logic                       r_dp_valid, w_dp_valid_nxt;
    logic                       r_write;
    logic [3:0]                 r_mask;
    logic [SLAVE_ADDRWIDTH-1:0] r_widx;

    logic                       w_rst;
    logic                       w_ready;
    logic                       w_accept;
    logic                       w_illegal;
    logic                       w_hi_nz;
    logic                       w_legal_accept;
    logic                       w_rd_en;
    logic [SLAVE_ADDRWIDTH-1:0] w_idx;
    logic [3:0]                 w_we;
    logic                       w_unused;

    assign w_rst   = ~HRESETn;
    assign w_idx   = HADDR[SLAVE_ADDRWIDTH+1:2];
    assign w_hi_nz = |(HADDR >> (SLAVE_ADDRWIDTH + 2));

    // Bus is held only in the first error cycle and while wait count remains
    assign w_ready = !((r_state == ST_ERR1) || ((r_state == ST_WAIT) && (r_cnt != 4'd0)));

    assign w_accept = HSEL && HREADY && w_ready &&
                      ((HTRANS == NONSEQ) || (HTRANS == SEQ));

    assign w_illegal = (HSIZE > WORD) ||
                       ((HSIZE == HALFWORD) && HADDR[0]) ||
                       ((HSIZE == WORD) && (HADDR[1:0] != 2'b00)) ||
                       w_hi_nz;

    assign w_legal_accept = w_accept && !w_illegal;
    assign w_rd_en        = w_legal_accept && !HWRITE;

    // Write commits at the edge where its data phase completes; reset drops it
    assign w_we = (r_dp_valid && r_write && w_ready && HRESETn) ? r_mask : 4'b0000;

    assign HREADYOUT = w_ready;
    assign HRESP     = ((r_state == ST_ERR1) || (r_state == ST_ERR2)) ? ERROR : OKAY;

    // Burst type carries no meaning for a flat memory
    assign w_unused = ^HBURST;

    // Next-state: hold through ERR1 and wait countdown, else take a new transfer
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_dp_valid_nxt = r_dp_valid;
        if (r_state == ST_ERR1) begin
            w_state_nxt    = ST_ERR2;
            w_dp_valid_nxt = 1'b0;
        end else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
            w_cnt_nxt = r_cnt - 4'd1;
        end else if (w_accept && w_illegal) begin
            w_state_nxt    = ST_ERR1;
            w_dp_valid_nxt = 1'b0;
        end else if (w_accept) begin
            w_dp_valid_nxt = 1'b1;
            if (c_WAIT == 4'd0) begin
                w_state_nxt = ST_IDLE;
            end else begin
                w_state_nxt = ST_WAIT;
                w_cnt_nxt   = c_WAIT;
            end
        end else begin
            w_state_nxt    = ST_IDLE;
            w_dp_valid_nxt = 1'b0;
        end
    end

    // State register with synchronous active-low reset
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 4'd0;
            r_dp_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_dp_valid <= w_dp_valid_nxt;
        end
    end

    // Address-phase capture of a legal transfer for use in its data phase
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_write <= 1'b0;
            r_mask  <= 4'b0000;
            r_widx  <= '0;
        end else if (w_legal_accept) begin
            r_write <= HWRITE;
            r_mask  <= byte_mask(HSIZE, HADDR[1:0]);
            r_widx  <= w_idx;
        end
    end

    ahb_slave_ram #(
        .ADDR_W (SLAVE_ADDRWIDTH),
        .DEPTH  (c_MEM_DEPTH_L)
    ) u_ram (
        .clk     (HCLK),
        .rst     (w_rst),
        .i_we    (w_we),
        .i_waddr (r_widx),
        .i_wdata (HWDATA),
        .i_re    (w_rd_en),
        .i_raddr (w_idx),
        .o_rdata (HRDATA)
    );

endmodule
`default_nettype wire

// File: tb/tb_ahb_lite_slave_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_lite_slave_mem
// Description : Directed self-checking bench for ahb_lite_slave_mem, with a
//               zero-wait instance and a three-wait-state instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_lite_slave_mem;
    import ahb_lite_slave_mem_pkg::*;

    logic        clk;
    logic        rstn;
    logic        sel;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;

    logic        ro0, rs0, ro3, rs3;
    logic [31:0] rd0, rd3;
    logic        hsel0, hsel3;
    logic        hreadyout, hresp;
    logic [31:0] hrdata;

    int errors = 0;
    int checks = 0;

    assign hsel0     = hsel & ~sel;
    assign hsel3     = hsel & sel;
    assign hreadyout = sel ? ro3 : ro0;
    assign hresp     = sel ? rs3 : rs0;
    assign hrdata    = sel ? rd3 : rd0;

    ahb_lite_slave_mem #(.ADDRWIDTH(32), .DATAWIDTH(32), .SLAVE_ADDRWIDTH(10), .WAIT_STATES(0)) u_dut0 (
        .HCLK(clk), .HRESETn(rstn), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
        .HREADY(ro0), .HREADYOUT(ro0), .HRESP(rs0), .HRDATA(rd0)
    );

    ahb_lite_slave_mem #(.ADDRWIDTH(32), .DATAWIDTH(32), .SLAVE_ADDRWIDTH(10), .WAIT_STATES(3)) u_dut3 (
        .HCLK(clk), .HRESETn(rstn), .HSEL(hsel3), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
        .HREADY(ro3), .HREADYOUT(ro3), .HRESP(rs3), .HRDATA(rd3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single transfer; reports wait cycles, ERROR cycles and HRDATA at completion
    task automatic xfer(input logic [31:0] addr, input logic [2:0] size, input logic wr,
                        input logic [31:0] wdata, output int waits, output int errs,
                        output logic [31:0] rdata);
        hsel = 1'b1; haddr = addr; hsize = size; hwrite = wr; htrans = NONSEQ; hburst = SINGLE;
        tick();
        hsel = 1'b0; htrans = IDLE; hwdata = wdata;
        waits = 0; errs = 0;
        while (hreadyout !== 1'b1 && waits < 20) begin
            if (hresp === 1'b1) errs++;
            waits++;
            tick();
        end
        if (hresp === 1'b1) errs++;
        rdata = hrdata;
        tick();
    endtask

    task automatic test_reset();
        sel = 1'b0; hsel = 1'b0; htrans = IDLE; haddr = '0; hwrite = 1'b0;
        hsize = WORD; hburst = SINGLE; hwdata = '0; rstn = 1'b0;
        repeat (3) tick();
        rstn = 1'b1;
        checks++; if (hreadyout !== 1'b1) begin errors++; $display("FAIL reset_hreadyout: got %b expected 1", hreadyout); end
        checks++; if (hresp !== 1'b0) begin errors++; $display("FAIL reset_hresp: got %b expected 0", hresp); end
        checks++; if (hrdata !== 32'h0) begin errors++; $display("FAIL reset_hrdata: got %h expected 00000000", hrdata); end
        checks++; if (rd3 !== 32'h0) begin errors++; $display("FAIL reset_hrdata_ws3: got %h expected 00000000", rd3); end
    endtask

    task automatic test_word_rw();
        int w, e; logic [31:0] rd;
        sel = 1'b0;
        xfer(32'h010, WORD, 1'b1, 32'hDEADBEEF, w, e, rd);
        checks++; if (w !== 0) begin errors++; $display("FAIL wr_waits: got %0d expected 0", w); end
        checks++; if (e !== 0) begin errors++; $display("FAIL wr_resp: got %0d error cycles expected 0", e); end
        xfer(32'h010, WORD, 1'b0, 32'h0, w, e, rd);
        checks++; if (w !== 0) begin errors++; $display("FAIL rd_waits: got %0d expected 0", w); end
        checks++; if (e !== 0) begin errors++; $display("FAIL rd_resp: got %0d error cycles expected 0", e); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h expected deadbeef", rd); end
    endtask

    task automatic test_byte_lanes();
        int w, e; logic [31:0] rd;
        sel = 1'b0;
        xfer(32'h020, WORD, 1'b1, 32'h11223344, w, e, rd);
        xfer(32'h021, BYTE, 1'b1, 32'hAAAAAAAA, w, e, rd);
        xfer(32'h020, WORD, 1'b0, 32'h0, w, e, rd);
        checks++; if (rd !== 32'h1122AA44) begin errors++; $display("FAIL byte_lane1: got %h expected 1122aa44", rd); end
        xfer(32'h022, HALFWORD, 1'b1, 32'hBBBBBBBB, w, e, rd);
        xfer(32'h020, WORD, 1'b0, 32'h0, w, e, rd);
        checks++; if (rd !== 32'hBBBBAA44) begin errors++; $display("FAIL half_upper: got %h expected bbbbaa44", rd); end
    endtask

    task automatic test_back_to_back();
        int w, e; logic [31:0] rd;
        sel = 1'b0;
        xfer(32'h030, WORD, 1'b1, 32'h12345678, w, e, rd);
        hsel = 1'b1; haddr = 32'h030; hsize = WORD; hwrite = 1'b1; htrans = NONSEQ;
        tick();
        hwdata = 32'hCAFEF00D; hwrite = 1'b0; htrans = NONSEQ;
        checks++; if (hreadyout !== 1'b1) begin errors++; $display("FAIL b2b_wr_ready: got %b expected 1", hreadyout); end
        tick();
        hsel = 1'b0; htrans = IDLE;
        checks++; if (hrdata !== 32'hCAFEF00D) begin errors++; $display("FAIL b2b_forward: got %h expected cafef00d", hrdata); end
        checks++; if (hresp !== 1'b0) begin errors++; $display("FAIL b2b_resp: got %b expected 0", hresp); end
        tick();
        xfer(32'h030, WORD, 1'b0, 32'h0, w, e, rd);
        checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL b2b_commit: got %h expected cafef00d", rd); end
    endtask

    task automatic test_errors();
        int w, e; logic [31:0] rd;
        logic [31:0] ea [4] = '{32'h002, 32'h004, 32'h1000, 32'h001};
        logic [2:0]  es [4] = '{WORD, WORD8, WORD, HALFWORD};
        sel = 1'b0;
        xfer(32'h000, WORD, 1'b1, 32'h01020304, w, e, rd);
        xfer(32'h004, WORD, 1'b1, 32'h05060708, w, e, rd);
        xfer(32'h004, WORD, 1'b0, 32'h0, w, e, rd);
        for (int i = 0; i < 4; i++) begin
            xfer(ea[i], es[i], 1'b1, 32'hFFFFFFFF, w, e, rd);
            checks++; if (w !== 1) begin errors++; $display("FAIL err%0d_low_cycles: got %0d expected 1", i, w); end
            checks++; if (e !== 2) begin errors++; $display("FAIL err%0d_error_cycles: got %0d expected 2", i, e); end
            checks++; if (rd !== 32'h05060708) begin errors++; $display("FAIL err%0d_hrdata_held: got %h expected 05060708", i, rd); end
        end
        xfer(32'h000, WORD, 1'b0, 32'h0, w, e, rd);
        checks++; if (rd !== 32'h01020304) begin errors++; $display("FAIL err_mem0: got %h expected 01020304", rd); end
        checks++; if (e !== 0) begin errors++; $display("FAIL err_recover_resp: got %0d expected 0", e); end
        xfer(32'h004, WORD, 1'b0, 32'h0, w, e, rd);
        checks++; if (rd !== 32'h05060708) begin errors++; $display("FAIL err_mem1: got %h expected 05060708", rd); end
    endtask

    task automatic test_wait_burst();
        int w, e, lows; logic [31:0] rd, exp_d; logic stable;
        sel = 1'b1;
        for (int i = 0; i < 4; i++) begin
            xfer(32'h040 + 32'(4*i), WORD, 1'b1, 32'hA0000000 + 32'(i), w, e, rd);
            if (i == 0) begin
                checks++; if (w !== 3) begin errors++; $display("FAIL ws_write_waits: got %0d expected 3", w); end
            end
        end
        hsel = 1'b1; hburst = INCR4; hsize = WORD; hwrite = 1'b0; haddr = 32'h040; htrans = NONSEQ;
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                haddr = 32'h040 + 32'(4*(i+1)); htrans = SEQ;
            end else begin
                hsel = 1'b0; htrans = IDLE;
            end
            exp_d = 32'hA0000000 + 32'(i);
            lows = 0; stable = 1'b1;
            for (int c = 0; c < 8; c++) begin
                if (hrdata !== exp_d) stable = 1'b0;
                if (hreadyout === 1'b1) break;
                lows++;
                tick();
            end
            checks++; if (lows !== 3) begin errors++; $display("FAIL burst_beat%0d_waits: got %0d expected 3", i, lows); end
            checks++; if (stable !== 1'b1) begin errors++; $display("FAIL burst_beat%0d_data: got %h expected stable %h", i, hrdata, exp_d); end
            tick();
        end
        hburst = SINGLE;
    endtask

    task automatic test_reset_in_wait();
        int w, e; logic [31:0] rd;
        sel = 1'b1;
        xfer(32'h050, WORD, 1'b1, 32'h55AA55AA, w, e, rd);
        hsel = 1'b1; haddr = 32'h050; hsize = WORD; hwrite = 1'b1; htrans = NONSEQ;
        tick();
        hsel = 1'b0; htrans = IDLE; hwdata = 32'h99999999;
        checks++; if (hreadyout !== 1'b0) begin errors++; $display("FAIL rstwait_in_wait: got %b expected 0", hreadyout); end
        tick();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        checks++; if (hreadyout !== 1'b1) begin errors++; $display("FAIL rstwait_hreadyout: got %b expected 1", hreadyout); end
        checks++; if (hresp !== 1'b0) begin errors++; $display("FAIL rstwait_hresp: got %b expected 0", hresp); end
        checks++; if (hrdata !== 32'h0) begin errors++; $display("FAIL rstwait_hrdata: got %h expected 00000000", hrdata); end
        xfer(32'h050, WORD, 1'b0, 32'h0, w, e, rd);
        checks++; if (rd !== 32'h55AA55AA) begin errors++; $display("FAIL rstwait_old_value: got %h expected 55aa55aa", rd); end
        checks++; if (w !== 3) begin errors++; $display("FAIL rstwait_read_waits: got %0d expected 3", w); end
    endtask

    initial begin
        test_reset();
        test_word_rw();
        test_byte_lanes();
        test_back_to_back();
        test_errors();
        test_wait_burst();
        test_reset_in_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
